// File: rtl/cac_result_collector_if.sv
// Lane-side and beat-side signals of the Cac result collector.
// slave is the collector's view, master is the driver/consumer view.
interface cac_result_collector_if #(
   parameter int DATAWIDTH = 16,
   parameter int DEPTH     = 4
) ();
   localparam int W  = DATAWIDTH + 1;
   localparam int OW = $clog2(DEPTH) + 1;

   logic          i_valid_A;
   logic          i_valid_B;
   logic          i_valid_C;
   logic          i_valid_D;
   logic [W-1:0]  i_data_A;
   logic [W-1:0]  i_data_B;
   logic [W-1:0]  i_data_C;
   logic [W-1:0]  i_data_D;
   logic          i_ready;
   logic          i_clr_err;
   logic          o_valid;
   logic [W-1:0]  o_data_A;
   logic [W-1:0]  o_data_B;
   logic [W-1:0]  o_data_C;
   logic [W-1:0]  o_data_D;
   logic [3:0]    o_overflow;
   logic [15:0]   o_beat_cnt;
   logic [OW-1:0] o_occ_max;

   modport master (
      output i_valid_A, i_valid_B, i_valid_C, i_valid_D,
      output i_data_A, i_data_B, i_data_C, i_data_D,
      output i_ready, i_clr_err,
      input  o_valid,
      input  o_data_A, o_data_B, o_data_C, o_data_D,
      input  o_overflow, o_beat_cnt, o_occ_max
   );

   modport slave (
      input  i_valid_A, i_valid_B, i_valid_C, i_valid_D,
      input  i_data_A, i_data_B, i_data_C, i_data_D,
      input  i_ready, i_clr_err,
      output o_valid,
      output o_data_A, o_data_B, o_data_C, o_data_D,
      output o_overflow, o_beat_cnt, o_occ_max
   );
endinterface

// File: rtl/cac_result_collector.sv
// Re-aligns four independent Cac result lanes into beats through
// per-lane FIFOs; overflow is flagged, never stalled upstream.
module cac_result_collector #(
   parameter int DATAWIDTH = 16,
   parameter int DEPTH     = 4
) (
   input logic                    clk,
   input logic                    rst,
   cac_result_collector_if.slave  bus
);
   localparam int W  = DATAWIDTH + 1;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [W-1:0]  din [4];
   logic [3:0]    push;

   logic [W-1:0]  mem_q [4][DEPTH];
   logic [W-1:0]  mem_d [4][DEPTH];
   logic [AW-1:0] wp_q  [4];
   logic [AW-1:0] wp_d  [4];
   logic [AW-1:0] rp_q  [4];
   logic [AW-1:0] rp_d  [4];
   logic [CW-1:0] cnt_q [4];
   logic [CW-1:0] cnt_d [4];

   logic [W-1:0]  dat_q [4];
   logic [W-1:0]  dat_d [4];
   logic          vld_q;
   logic          vld_d;
   logic [3:0]    ovf_q;
   logic [3:0]    ovf_d;
   logic [15:0]   beat_q;
   logic [15:0]   beat_d;
   logic [CW-1:0] occ_q;
   logic [CW-1:0] occ_d;

   logic          all_ne;
   logic          pop;
   logic          xfer;
   logic [3:0]    full;
   logic [3:0]    acc;
   logic [3:0]    new_ovf;

   // Lane index 0..3 maps to A..D
   always_comb begin
      din[0]  = bus.i_data_A;
      din[1]  = bus.i_data_B;
      din[2]  = bus.i_data_C;
      din[3]  = bus.i_data_D;
      push[0] = bus.i_valid_A;
      push[1] = bus.i_valid_B;
      push[2] = bus.i_valid_C;
      push[3] = bus.i_valid_D;
   end

   always_comb begin
      mem_d   = mem_q;
      wp_d    = wp_q;
      rp_d    = rp_q;
      cnt_d   = cnt_q;
      dat_d   = dat_q;
      vld_d   = vld_q;
      beat_d  = beat_q;
      full    = '0;
      acc     = '0;
      new_ovf = '0;
      occ_d   = '0;

      all_ne = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (cnt_q[i] == '0) all_ne = 1'b0;
      end
      pop  = all_ne && (!vld_q || bus.i_ready);
      xfer = vld_q && bus.i_ready;

      for (int i = 0; i < 4; i++) begin
         full[i] = (cnt_q[i] == CW'(DEPTH));
         // A full lane still accepts when the beat pops this edge
         acc[i]  = push[i] && (!full[i] || pop);
         if (push[i] && full[i] && !pop)
            new_ovf[3-i] = 1'b1;
         if (acc[i]) begin
            mem_d[i][wp_q[i]] = din[i];
            wp_d[i] = wp_q[i] + AW'(1);
         end
         if (pop) begin
            dat_d[i] = mem_q[i][rp_q[i]];
            rp_d[i]  = rp_q[i] + AW'(1);
         end
         cnt_d[i] = cnt_q[i] + CW'(acc[i]) - CW'(pop);
         if (cnt_d[i] > occ_d) occ_d = cnt_d[i];
      end

      if (pop)       vld_d = 1'b1;
      else if (xfer) vld_d = 1'b0;

      if (xfer) beat_d = beat_q + 16'd1;

      // A fresh overflow beats a simultaneous clear
      ovf_d = (ovf_q & ~{4{bus.i_clr_err}}) | new_ovf;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < DEPTH; j++)
               mem_q[i][j] <= '0;
            wp_q[i]  <= '0;
            rp_q[i]  <= '0;
            cnt_q[i] <= '0;
            dat_q[i] <= '0;
         end
         vld_q  <= 1'b0;
         ovf_q  <= '0;
         beat_q <= '0;
         occ_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         cnt_q  <= cnt_d;
         dat_q  <= dat_d;
         vld_q  <= vld_d;
         ovf_q  <= ovf_d;
         beat_q <= beat_d;
         occ_q  <= occ_d;
      end
   end

   assign bus.o_valid    = vld_q;
   assign bus.o_data_A   = dat_q[0];
   assign bus.o_data_B   = dat_q[1];
   assign bus.o_data_C   = dat_q[2];
   assign bus.o_data_D   = dat_q[3];
   assign bus.o_overflow = ovf_q;
   assign bus.o_beat_cnt = beat_q;
   assign bus.o_occ_max  = occ_q;

endmodule

// File: tb/tb_cac_result_collector.sv
// Bench for cac_result_collector: fixed vectors, corner sequences
// and random traffic against a queue-based reference model.
module tb_cac_result_collector;
   localparam int DW = 16;
   localparam int DP = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cac_result_collector_if #(.DATAWIDTH(DW), .DEPTH(DP)) bus ();

   cac_result_collector #(.DATAWIDTH(DW), .DEPTH(DP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int nvec = 0;
   int nmis = 0;
   bit chk_on = 1'b1;

   // Reference model: one queue per lane plus the output beat
   logic [16:0] mq [4][$];
   logic [16:0] md [4];
   logic        mv;
   logic [3:0]  movf;
   logic [15:0] mcnt;
   logic [2:0]  mocc;

   typedef struct {
      bit          rst_first;
      logic [3:0]  v;
      logic [67:0] d;
      logic        rdy;
      logic        exp_vld;
      bit          chk_d;
      logic [67:0] exp_d;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string nm, input logic [67:0] act,
                      input logic [67:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [67:0] odata();
      return {bus.o_data_A, bus.o_data_B, bus.o_data_C, bus.o_data_D};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         mq[i].delete();
         md[i] = '0;
      end
      mv = 0; movf = 0; mcnt = 0; mocc = 0;
   endtask

   task automatic model_step(input logic [3:0] v, input logic [67:0] d,
                             input logic rdy, input logic clr);
      bit pop, xfer;
      logic [3:0] nov;
      int mx;
      pop  = 1;
      for (int i = 0; i < 4; i++)
         if (mq[i].size() == 0) pop = 0;
      if (mv && !rdy) pop = 0;
      xfer = mv && rdy;
      nov  = 0;
      if (pop)
         for (int i = 0; i < 4; i++) md[i] = mq[i].pop_front();
      for (int i = 0; i < 4; i++) begin
         if (v[3-i]) begin
            if (mq[i].size() < DP) mq[i].push_back(d[67-17*i -: 17]);
            else nov[3-i] = 1'b1;
         end
      end
      if (pop) mv = 1;
      else if (xfer) mv = 0;
      if (xfer) mcnt = mcnt + 16'd1;
      movf = (clr ? 4'b0 : movf) | nov;
      mx = 0;
      for (int i = 0; i < 4; i++)
         if (mq[i].size() > mx) mx = mq[i].size();
      mocc = 3'(mx);
   endtask

   task automatic check_model();
      chk("m_valid", {67'b0, bus.o_valid}, {67'b0, mv});
      chk("m_data", odata(), {md[0], md[1], md[2], md[3]});
      chk("m_ovf", {64'b0, bus.o_overflow}, {64'b0, movf});
      chk("m_cnt", {52'b0, bus.o_beat_cnt}, {52'b0, mcnt});
      chk("m_occ", {65'b0, bus.o_occ_max}, {65'b0, mocc});
   endtask

   task automatic tick(input logic [3:0] v, input logic [67:0] d,
                       input logic rdy, input logic clr);
      bus.i_valid_A = v[3];
      bus.i_valid_B = v[2];
      bus.i_valid_C = v[1];
      bus.i_valid_D = v[0];
      bus.i_data_A  = d[67:51];
      bus.i_data_B  = d[50:34];
      bus.i_data_C  = d[33:17];
      bus.i_data_D  = d[16:0];
      bus.i_ready   = rdy;
      bus.i_clr_err = clr;
      model_step(v, d, rdy, clr);
      @(posedge clk);
      #1;
      if (chk_on) check_model();
   endtask

   task automatic drive_idle();
      bus.i_valid_A = 0; bus.i_valid_B = 0;
      bus.i_valid_C = 0; bus.i_valid_D = 0;
      bus.i_data_A = '0; bus.i_data_B = '0;
      bus.i_data_C = '0; bus.i_data_D = '0;
      bus.i_ready = 0; bus.i_clr_err = 0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      drive_idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {67'b0, bus.o_valid}, 68'd0);
      chk("rst_data", odata(), 68'd0);
      chk("rst_ovf", {64'b0, bus.o_overflow}, 68'd0);
      chk("rst_cnt", {52'b0, bus.o_beat_cnt}, 68'd0);
      chk("rst_occ", {65'b0, bus.o_occ_max}, 68'd0);
      rst = 1'b1;
   endtask

   function automatic logic [67:0] rep4(input logic [16:0] x);
      return {x, x, x, x};
   endfunction

   function automatic logic [67:0] rnd68();
      return {4'($urandom), $urandom, $urandom};
   endfunction

   initial begin
      int n;
      drive_idle();

      tbl[0] = '{1'b1, 4'hF, {17'h100, 17'h200, 17'h300, 17'h400},
                 1'b1, 1'b0, 1'b0, 68'h0, 16'd0};
      tbl[1] = '{1'b0, 4'h0, 68'h0, 1'b1, 1'b1, 1'b1,
                 {17'h100, 17'h200, 17'h300, 17'h400}, 16'd0};
      tbl[2] = '{1'b0, 4'h0, 68'h0, 1'b1, 1'b0, 1'b0, 68'h0, 16'd1};
      tbl[3] = '{1'b1, 4'h8, {17'h11, 17'h0, 17'h0, 17'h0},
                 1'b1, 1'b0, 1'b0, 68'h0, 16'd0};
      tbl[4] = '{1'b0, 4'h4, {17'h0, 17'h22, 17'h0, 17'h0},
                 1'b1, 1'b0, 1'b0, 68'h0, 16'd0};
      tbl[5] = '{1'b0, 4'h1, {17'h0, 17'h0, 17'h0, 17'h44},
                 1'b1, 1'b0, 1'b0, 68'h0, 16'd0};
      tbl[6] = '{1'b0, 4'h2, {17'h0, 17'h0, 17'h33, 17'h0},
                 1'b1, 1'b0, 1'b0, 68'h0, 16'd0};
      tbl[7] = '{1'b0, 4'h0, 68'h0, 1'b1, 1'b1, 1'b1,
                 {17'h11, 17'h22, 17'h33, 17'h44}, 16'd0};
      tbl[8] = '{1'b0, 4'h0, 68'h0, 1'b1, 1'b0, 1'b0, 68'h0, 16'd1};

      for (int i = 0; i < 9; i++) begin
         if (tbl[i].rst_first) do_reset();
         tick(tbl[i].v, tbl[i].d, tbl[i].rdy, 1'b0);
         chk($sformatf("tbl%0d_vld", i), {67'b0, bus.o_valid},
             {67'b0, tbl[i].exp_vld});
         if (tbl[i].chk_d)
            chk($sformatf("tbl%0d_data", i), odata(), tbl[i].exp_d);
         chk($sformatf("tbl%0d_cnt", i), {52'b0, bus.o_beat_cnt},
             {52'b0, tbl[i].exp_cnt});
      end

      // Backpressure with overflow, drain, then clear
      do_reset();
      for (int k = 1; k <= 6; k++) tick(4'hF, rep4(17'(k)), 1'b0, 1'b0);
      chk("bp_ovf", {64'b0, bus.o_overflow}, 68'hF);
      chk("bp_occ", {65'b0, bus.o_occ_max}, 68'd4);
      for (int k = 1; k <= 5; k++) begin
         chk($sformatf("bp_vld%0d", k), {67'b0, bus.o_valid}, 68'd1);
         chk($sformatf("bp_beat%0d", k), odata(), rep4(17'(k)));
         tick(4'h0, 68'h0, 1'b1, 1'b0);
      end
      chk("bp_done", {67'b0, bus.o_valid}, 68'd0);
      chk("bp_cnt", {52'b0, bus.o_beat_cnt}, 68'd5);
      tick(4'h0, 68'h0, 1'b0, 1'b1);
      chk("bp_clr", {64'b0, bus.o_overflow}, 68'd0);

      // Full lanes with push and pop on the same edge
      do_reset();
      for (int k = 1; k <= 5; k++) tick(4'hF, rep4(17'(k)), 1'b0, 1'b0);
      chk("fp_occ", {65'b0, bus.o_occ_max}, 68'd4);
      for (int k = 1; k <= 8; k++) begin
         tick(4'hF, rep4(17'(k + 5)), 1'b1, 1'b0);
         chk($sformatf("fp_ovf%0d", k), {64'b0, bus.o_overflow}, 68'd0);
         chk($sformatf("fp_cnt%0d", k), {52'b0, bus.o_beat_cnt},
             68'(k));
         chk($sformatf("fp_data%0d", k), odata(), rep4(17'(k + 1)));
      end

      // Asynchronous reset mid-cycle with data in flight
      do_reset();
      for (int k = 1; k <= 4; k++) tick(4'hF, rep4(17'(k)), 1'b0, 1'b0);
      tick(4'h8, rep4(17'h5), 1'b0, 1'b0);
      tick(4'h8, rep4(17'h6), 1'b0, 1'b0);
      chk("ar_pre_ovf", {64'b0, bus.o_overflow}, 68'h8);
      drive_idle();
      #3 rst = 1'b0;
      #1;
      chk("ar_valid", {67'b0, bus.o_valid}, 68'd0);
      chk("ar_occ", {65'b0, bus.o_occ_max}, 68'd0);
      chk("ar_ovf", {64'b0, bus.o_overflow}, 68'd0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      tick(4'hF, {17'h1A1, 17'h1B2, 17'h1C3, 17'h1D4}, 1'b1, 1'b0);
      chk("ar_lat1", {67'b0, bus.o_valid}, 68'd0);
      tick(4'h0, 68'h0, 1'b1, 1'b0);
      chk("ar_lat2", {67'b0, bus.o_valid}, 68'd1);
      chk("ar_data", odata(), {17'h1A1, 17'h1B2, 17'h1C3, 17'h1D4});
      tick(4'h0, 68'h0, 1'b1, 1'b0);
      chk("ar_only", {67'b0, bus.o_valid}, 68'd0);

      // Random traffic, two load profiles
      do_reset();
      for (int c = 0; c < 600; c++)
         tick(4'($urandom), rnd68(), $urandom_range(0, 3) != 0,
              $urandom_range(0, 15) == 0);
      for (int c = 0; c < 400; c++)
         tick(4'($urandom) | 4'($urandom), rnd68(),
              $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0);

      // Beat counter wrap
      do_reset();
      chk_on = 1'b0;
      n = 0;
      while (mcnt != 16'hFFFF && n < 70000) begin
         tick(4'hF, rep4(17'(n)), 1'b1, 1'b0);
         n++;
      end
      chk_on = 1'b1;
      chk("wrap_pre", {52'b0, bus.o_beat_cnt}, 68'hFFFF);
      tick(4'hF, rep4(17'h7), 1'b1, 1'b0);
      chk("wrap", {52'b0, bus.o_beat_cnt}, 68'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule

// File: doc/cac_result_collector.md
Name: cac_result_collector

Overview:
- Sits on the output side of the Cac arithmetic top (mul/div/sqrt/add-tree pipeline).
- Accepts the four independently-valid result lanes A–D, each DATAWIDTH+1 bits wide.
- Re-aligns the lanes into single four-lane result beats through per-lane FIFOs, then presents each beat downstream on a valid/ready handshake.
- The upstream top has no backpressure, so lane overflow is detected and flagged, never stalled.

Parameters:
- DATAWIDTH, 16, operand width of the Cac top; lane data is DATAWIDTH+1 bits.
- DEPTH, 4, entries per lane FIFO; must be a power of 2, ≥2.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- i_valid_A, i_valid_B, i_valid_C, i_valid_D  input  1 each  per-lane result valid from the Cac top
- i_data_A, i_data_B, i_data_C, i_data_D  input  DATAWIDTH+1 each  per-lane result
- i_ready  input  1  downstream accepts the beat
- i_clr_err  input  1  synchronous clear of the overflow flags
- o_valid  output  1  beat available
- o_data_A, o_data_B, o_data_C, o_data_D  output  DATAWIDTH+1 each  aligned beat
- o_overflow  output  4  sticky per-lane overflow; bit3=A, bit2=B, bit1=C, bit0=D
- o_beat_cnt  output  16  beats delivered (o_valid && i_ready), wraps
- o_occ_max  output  $clog2(DEPTH)+1  maximum current occupancy across the four FIFOs

Behaviour:
- Reset (rst=0, asynchronous):
  - All FIFOs empty; pointers = 0.
  - o_valid=0, o_data_*=0, o_overflow=0, o_beat_cnt=0, o_occ_max=0.
  - Reset is honoured mid-operation; all in-flight data is discarded.
  - First push is accepted on the first rising edge after rst deasserts.
- Lane push:
  - i_valid_X=1 at a rising edge writes i_data_X into FIFO X.
  - Lanes are fully independent; any skew between lanes is allowed.
- Full-lane handling:
  - Push to a full FIFO with no pop in the same cycle: data dropped, o_overflow[X] set, FIFO contents unchanged.
  - Push and pop in the same cycle on a full FIFO: both succeed, no overflow.
- Beat formation:
  - Output register load condition: all four FIFOs non-empty AND (o_valid==0 OR i_ready==1).
  - On load: all four heads pop in the same cycle into o_data_*, and o_valid=1.
  - Lanes never pop individually.
- Handshake:
  - Transfer occurs when o_valid && i_ready at a rising edge.
  - If no new beat loads on a transfer, o_valid drops to 0 the next cycle.
  - While o_valid=1 and i_ready=0, o_data_* are held stable.
  - Back-to-back transfers sustain 1 beat/cycle.
- Latency:
  - Lanes all valid in cycle N with empty FIFOs and i_ready=1 → o_valid=1 in cycle N+2.
  - In general, o_valid follows 2 cycles after the latest lane of that beat arrives.
- Capacity: one beat in the output register plus DEPTH beats per lane.
- Flags and counters:
  - o_overflow is sticky until i_clr_err=1.
  - If a new overflow and i_clr_err occur in the same cycle, set wins.
  - o_beat_cnt increments by 1 per transfer and wraps 0xFFFF→0x0000.
  - o_occ_max is registered and reflects FIFO occupancies after the current edge.
- Data is passed through unmodified; the block does no arithmetic on lane values.

Test Plan:
- Aligned lanes: after reset, cycle 0 all valid with A=0x00100, B=0x00200, C=0x00300, D=0x00400, i_ready=1 → o_valid=1 in cycle 2 with the same values; o_beat_cnt=1 in cycle 3.
- Skewed lanes: A=0x00011 in cycle 0, B=0x00022 in cycle 1, D=0x00044 in cycle 2, C=0x00033 in cycle 3 → o_valid first high in cycle 5 with A..D=0x00011/0x00022/0x00033/0x00044; o_valid low in cycles 0–4.
- Backpressure/overflow: i_ready=0, push 6 aligned beats with values 1..6 (DEPTH=4):
  - Beat 1 is held in o_data_*; beats 2–5 are buffered; o_overflow=4'b1111 after beat 6.
  - Raise i_ready → beats 1,2,3,4,5 delivered on consecutive cycles, o_beat_cnt=5.
  - Pulse i_clr_err → o_overflow=0.
- Full push+pop: fill lane A (DEPTH beats, others fill too), then i_ready=1 with a simultaneous new aligned push each cycle → no overflow bit set; stream continues at 1 beat/cycle.
- Counter wrap: force o_beat_cnt to 0xFFFF via 65535 transfers (or a hierarchical deposit), transfer one beat → o_beat_cnt=0x0000.
- Reset mid-operation: with 3 beats buffered and o_valid=1, drive rst=0 asynchronously mid-cycle → o_valid=0, o_occ_max=0, o_overflow=0 immediately. After release, one aligned push → o_valid in 2 cycles with the new data only.
